// File: rtl/vx_cta_scheduler_pkg.sv
// Shared types for the CTA scheduler: the descriptor carried from the kernel
// management unit to the cores, the scheduler FSM states, and the warp-need rule.
package vx_cta_scheduler_pkg;

  typedef struct packed {
    logic [7:0]  num_warps;
    logic [31:0] start_pc;
    logic [31:0] param;
    logic [15:0] cta_x;
    logic [15:0] cta_y;
    logic [15:0] cta_z;
    logic [31:0] cta_id;
    logic [7:0]  remain_mask;
  } cta_req_t;

  localparam int CTA_REQ_W = $bits(cta_req_t);

  typedef enum logic [1:0] {
    CTA_IDLE  = 2'd0,
    CTA_HOLD  = 2'd1,
    CTA_ISSUE = 2'd2
  } cta_state_e;

  // A CTA that asks for zero warps still occupies one slot.
  function automatic logic [31:0] cta_need(input cta_req_t req);
    return (req.num_warps == '0) ? 32'd1 : {24'd0, req.num_warps};
  endfunction

endpackage

// File: rtl/vx_cta_scheduler_if.sv
// Bundle of the descriptor input stream, the per-core dispatch bus, the
// per-core completion reports and the status flags of the CTA scheduler.
interface vx_cta_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int NUM_WARPS = 4
);
  import vx_cta_scheduler_pkg::*;

  localparam int NW_BITS = $clog2(NUM_WARPS + 1);

  logic                         in_valid;
  cta_req_t                     in_data;
  logic                         in_ready;
  logic [NUM_CORES-1:0]         out_valid;
  cta_req_t                     out_data;
  logic [NUM_CORES-1:0]         out_ready;
  logic [NUM_CORES-1:0]         done_valid;
  logic [NUM_CORES*NW_BITS-1:0] done_warps;
  logic                         busy;
  logic                         err;

  modport slave (
    input  in_valid, in_data, out_ready, done_valid, done_warps,
    output in_ready, out_valid, out_data, busy, err
  );

  modport master (
    output in_valid, in_data, out_ready, done_valid, done_warps,
    input  in_ready, out_valid, out_data, busy, err
  );

endinterface

// File: rtl/vx_cta_scheduler_rr_find_first.sv
// Round-robin picker: returns the first eligible core at or after the pointer,
// wrapping around to the lowest eligible core below it.
module vx_rr_find_first #(
  parameter  int NUM_CORES = 4,
  localparam int PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] i_elig,
  input  logic [PTR_W-1:0]     i_rr_ptr,
  output logic [PTR_W-1:0]     o_sel,
  output logic                 o_sel_valid
);

  // Lowest eligible core overall, overridden by the lowest one at or after the pointer.
  always_comb begin
    o_sel       = '0;
    o_sel_valid = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (i_elig[i]) begin
        o_sel       = PTR_W'(i);
        o_sel_valid = 1'b1;
      end
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (i_elig[i] && (PTR_W'(i) >= i_rr_ptr)) begin
        o_sel = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/vx_cta_scheduler.sv
// CTA scheduler: holds one descriptor at a time, dispatches it to a core with
// enough free warp slots (round-robin among eligible cores) and tracks the
// free-warp count of every core as CTAs are dispatched and retired.
module vx_cta_scheduler
  import vx_cta_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_WARPS = 4
) (
  input logic               clk,
  input logic               reset,
  vx_cta_scheduler_if.slave bus
);

  localparam int NW_BITS = $clog2(NUM_WARPS + 1);
  localparam int PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  cta_state_e           r_state;
  cta_state_e           w_next_state;
  cta_req_t             r_hold;
  cta_req_t             r_out_data;
  logic [NUM_CORES-1:0] r_out_valid;
  logic [NW_BITS-1:0]   r_free [NUM_CORES];
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_sel;
  logic                 r_err;

  logic [31:0]          w_need;
  logic                 w_too_big;
  logic [NUM_CORES-1:0] w_elig;
  logic [PTR_W-1:0]     w_sel;
  logic                 w_sel_valid;
  logic                 w_dispatch;
  logic                 w_drop;
  logic                 w_retire;
  logic [31:0]          w_sum [NUM_CORES];
  logic [NW_BITS-1:0]   w_next_free [NUM_CORES];
  logic [NUM_CORES-1:0] w_overflow;
  logic                 w_not_full;

  assign w_need    = cta_need(r_hold);
  assign w_too_big = w_need > 32'(NUM_WARPS);

  vx_rr_find_first #(.NUM_CORES(NUM_CORES)) u_rr (
    .i_elig      (w_elig),
    .i_rr_ptr    (r_rr_ptr),
    .o_sel       (w_sel),
    .o_sel_valid (w_sel_valid)
  );

  // Next-state logic and the one-cycle actions taken in each state.
  always_comb begin
    w_next_state = r_state;
    w_dispatch   = 1'b0;
    w_drop       = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      CTA_IDLE: begin
        if (bus.in_valid) w_next_state = CTA_HOLD;
      end
      CTA_HOLD: begin
        if (w_too_big) begin
          w_drop       = 1'b1;
          w_next_state = CTA_IDLE;
        end else if (w_sel_valid) begin
          w_dispatch   = 1'b1;
          w_next_state = CTA_ISSUE;
        end
      end
      CTA_ISSUE: begin
        if (bus.out_ready[r_sel]) begin
          w_retire     = 1'b1;
          w_next_state = CTA_IDLE;
        end
      end
      default: w_next_state = CTA_IDLE;
    endcase
  end

  // Per-core eligibility and net free-warp update (+completion -dispatch, clamped).
  always_comb begin
    w_not_full = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_elig[i]      = {{(32-NW_BITS){1'b0}}, r_free[i]} >= w_need;
      w_sum[i]       = {{(32-NW_BITS){1'b0}}, r_free[i]}
                     + (bus.done_valid[i] ? {{(32-NW_BITS){1'b0}}, bus.done_warps[i*NW_BITS +: NW_BITS]} : 32'd0)
                     - ((w_dispatch && (w_sel == PTR_W'(i))) ? w_need : 32'd0);
      w_overflow[i]  = w_sum[i] > 32'(NUM_WARPS);
      w_next_free[i] = w_overflow[i] ? NW_BITS'(NUM_WARPS) : w_sum[i][NW_BITS-1:0];
      if (r_free[i] != NW_BITS'(NUM_WARPS)) w_not_full = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= CTA_IDLE;
    else       r_state <= w_next_state;
  end

  // Datapath registers: hold buffer, dispatch outputs, counters, pointer and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_rr_ptr    <= '0;
      r_sel       <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) r_free[i] <= NW_BITS'(NUM_WARPS);
    end else begin
      for (int i = 0; i < NUM_CORES; i++) r_free[i] <= w_next_free[i];
      if ((r_state == CTA_IDLE) && bus.in_valid) r_hold <= bus.in_data;
      if (w_dispatch) begin
        r_out_valid <= NUM_CORES'(1) << w_sel;
        r_out_data  <= r_hold;
        r_sel       <= w_sel;
      end
      if (w_retire) begin
        r_out_valid <= '0;
        r_rr_ptr    <= (r_sel == PTR_W'(NUM_CORES - 1)) ? '0 : r_sel + PTR_W'(1);
      end
      if (w_drop || (|w_overflow)) r_err <= 1'b1;
    end
  end

  assign bus.in_ready  = (r_state == CTA_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = (r_state != CTA_IDLE) || w_not_full;
  assign bus.err       = r_err;

endmodule
